// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream synchronous FIFO.
package axis_pkg;

    localparam int unsigned AXIS_DATA_W = 32;
    localparam int unsigned AXIS_USER_W = 1;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0]   tdata;
        logic [AXIS_DATA_W/8-1:0] tstrb;
        logic [AXIS_USER_W-1:0]   tuser;
        logic                     tlast;
    } axis_payload_t;

    // Pointer carries one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned axis_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned axis_payload_width(input int unsigned dw, input int unsigned uw);
        return dw + dw / 8 + uw + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH  = 38,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through AXI-Stream FIFO with registered status outputs.
// Define AXIS_FIFO_PACKET_MODE_EN to hold output until a whole packet is stored.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      s_axis_TVALID,
    output logic                      s_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]     s_axis_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_TSTRB,
    input  logic [USER_WIDTH-1:0]     s_axis_TUSER,
    input  logic                      s_axis_TLAST,
    output logic                      m_axis_TVALID,
    input  logic                      m_axis_TREADY,
    output logic [DATA_WIDTH-1:0]     m_axis_TDATA,
    output logic [DATA_WIDTH/8-1:0]   m_axis_TSTRB,
    output logic [USER_WIDTH-1:0]     m_axis_TUSER,
    output logic                      m_axis_TLAST,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      s_almost_full
);

    localparam int unsigned PTR_W  = axis_ptr_width(DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;
    localparam int unsigned PAY_W  = axis_payload_width(DATA_WIDTH, USER_WIDTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic             tready_q, tready_d;
    logic             tvalid_q, tvalid_d;
    logic             afull_q, afull_d;
    logic             push_s, pop_s, empty_s, full_s;
    logic [PAY_W-1:0] wdata_s, rdata_s;

    assign push_s  = s_axis_TVALID && tready_q;
    assign pop_s   = tvalid_q && m_axis_TREADY;
    assign wdata_s = {s_axis_TDATA, s_axis_TSTRB, s_axis_TUSER, s_axis_TLAST};

    axis_fifo_ram #(
        .WIDTH  (PAY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (ACLK),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata_s)
    );

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
`endif

    // Next-state: pointers, occupancy and status flags as they will be after this edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_s};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_s};
        fill_d   = fill_q + {{(PTR_W-1){1'b0}}, push_s} - {{(PTR_W-1){1'b0}}, pop_s};
        empty_s  = (wr_ptr_d == rd_ptr_d);
        full_s   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                   (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]);
        tready_d = !full_s;
        afull_d  = (fill_d >= PTR_W'(AFULL_THRESH));
`ifdef AXIS_FIFO_PACKET_MODE_EN
        pkt_cnt_d = pkt_cnt_q + {{(PTR_W-1){1'b0}}, push_s && s_axis_TLAST}
                              - {{(PTR_W-1){1'b0}}, pop_s && rdata_s[0]};
        // Full override lets packets longer than DEPTH drain instead of deadlocking.
        tvalid_d  = !empty_s && ((pkt_cnt_d != {PTR_W{1'b0}}) || full_s);
`else
        tvalid_d  = !empty_s;
`endif
    end

    // State and registered status outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            fill_q    <= {PTR_W{1'b0}};
            tready_q  <= 1'b1;
            tvalid_q  <= 1'b0;
            afull_q   <= 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
            pkt_cnt_q <= {PTR_W{1'b0}};
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            tready_q  <= tready_d;
            tvalid_q  <= tvalid_d;
            afull_q   <= afull_d;
`ifdef AXIS_FIFO_PACKET_MODE_EN
            pkt_cnt_q <= pkt_cnt_d;
`endif
        end
    end

    assign s_axis_TREADY = tready_q;
    assign m_axis_TVALID = tvalid_q;
    assign fill_level    = fill_q;
    assign s_almost_full = afull_q;
    assign m_axis_TDATA  = rdata_s[PAY_W-1 -: DATA_WIDTH];
    assign m_axis_TSTRB  = rdata_s[USER_WIDTH+1 +: DATA_WIDTH/8];
    assign m_axis_TUSER  = rdata_s[1 +: USER_WIDTH];
    assign m_axis_TLAST  = rdata_s[0];

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed self-checking bench for axis_sync_fifo (DEPTH=16, default widths).
module tb_axis_sync_fifo;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        s_axis_TVALID = 1'b0;
    logic        s_axis_TREADY;
    logic [31:0] s_axis_TDATA = 32'h0;
    logic [3:0]  s_axis_TSTRB = 4'h0;
    logic [0:0]  s_axis_TUSER = 1'b0;
    logic        s_axis_TLAST = 1'b0;
    logic        m_axis_TVALID;
    logic        m_axis_TREADY = 1'b0;
    logic [31:0] m_axis_TDATA;
    logic [3:0]  m_axis_TSTRB;
    logic [0:0]  m_axis_TUSER;
    logic        m_axis_TLAST;
    logic [4:0]  fill_level;
    logic        s_almost_full;

    int tests = 0;
    int fails = 0;

    axis_sync_fifo dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .s_axis_TVALID (s_axis_TVALID),
        .s_axis_TREADY (s_axis_TREADY),
        .s_axis_TDATA  (s_axis_TDATA),
        .s_axis_TSTRB  (s_axis_TSTRB),
        .s_axis_TUSER  (s_axis_TUSER),
        .s_axis_TLAST  (s_axis_TLAST),
        .m_axis_TVALID (m_axis_TVALID),
        .m_axis_TREADY (m_axis_TREADY),
        .m_axis_TDATA  (m_axis_TDATA),
        .m_axis_TSTRB  (m_axis_TSTRB),
        .m_axis_TUSER  (m_axis_TUSER),
        .m_axis_TLAST  (m_axis_TLAST),
        .fill_level    (fill_level),
        .s_almost_full (s_almost_full)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        logic [37:0] q[$];
        logic [37:0] exp_w;
        logic [31:0] v32;
        logic        push, pop;
        int          sent, got, in_idx, out_idx;

        // Reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_valid", m_axis_TVALID, 1'b0);
        chk("rst_fill", fill_level, 5'd0);
        chk("rst_afull", s_almost_full, 1'b0);
        ARESETn = 1'b1;
        tick();
        chk("rst_tready", s_axis_TREADY, 1'b1);

        // Fill 16 words with the sink stalled
        for (int i = 0; i < 16; i++) begin
            v32 = i;
            s_axis_TVALID = 1'b1;
            s_axis_TDATA  = v32;
            s_axis_TSTRB  = v32[3:0];
            s_axis_TUSER  = v32[1];
            s_axis_TLAST  = v32[0];
`ifndef AXIS_FIFO_PACKET_MODE_EN
            if (i == 0) begin
                #1;
                chk("no_bypass", m_axis_TVALID, 1'b0);
            end
`endif
            tick();
            chk("fill_level", fill_level, i + 1);
            chk("fill_afull", s_almost_full, (i + 1 >= 14) ? 1'b1 : 1'b0);
`ifndef AXIS_FIFO_PACKET_MODE_EN
            if (i == 0) begin
                chk("lat_valid", m_axis_TVALID, 1'b1);
                chk("lat_data", m_axis_TDATA, 32'h0);
            end
`endif
        end
        chk("full_tready", s_axis_TREADY, 1'b0);

        // Push attempt while full must be ignored
        s_axis_TDATA = 32'h99;
        tick();
        chk("full_nopush", fill_level, 5'd16);
        chk("full_tready2", s_axis_TREADY, 1'b0);
        s_axis_TVALID = 1'b0;

        // Drain in order on consecutive edges
        m_axis_TREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v32 = i;
            chk("drain_valid", m_axis_TVALID, 1'b1);
            chk("drain_data", m_axis_TDATA, v32);
            chk("drain_strb", m_axis_TSTRB, v32[3:0]);
            chk("drain_user", m_axis_TUSER, v32[1]);
            chk("drain_last", m_axis_TLAST, v32[0]);
            tick();
        end
        chk("drain_empty", m_axis_TVALID, 1'b0);
        chk("drain_fill", fill_level, 5'd0);
        chk("drain_tready", s_axis_TREADY, 1'b1);
        chk("drain_afull", s_almost_full, 1'b0);
        m_axis_TREADY = 1'b0;

        // Simultaneous push and pop keeps occupancy
        s_axis_TVALID = 1'b1; s_axis_TDATA = 32'hA1; s_axis_TLAST = 1'b1;
        tick();
        chk("sim_fill0", fill_level, 5'd1);
        s_axis_TDATA = 32'hB2; m_axis_TREADY = 1'b1;
        #1;
        chk("sim_head", m_axis_TDATA, 32'hA1);
        tick();
        chk("sim_fill1", fill_level, 5'd1);
        chk("sim_next", m_axis_TDATA, 32'hB2);
        s_axis_TVALID = 1'b0;
        tick();
        chk("sim_empty", m_axis_TVALID, 1'b0);
        m_axis_TREADY = 1'b0;

        // Random streaming against a queue scoreboard
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            s_axis_TVALID = (sent < 1000) && ($urandom_range(1, 0) == 1);
            s_axis_TDATA  = $urandom;
            s_axis_TSTRB  = 4'($urandom_range(15, 0));
            s_axis_TUSER  = 1'($urandom_range(1, 0));
            s_axis_TLAST  = 1'($urandom_range(1, 0));
            m_axis_TREADY = ($urandom_range(1, 0) == 1);
            #1;
            push = s_axis_TVALID && s_axis_TREADY;
            pop  = m_axis_TVALID && m_axis_TREADY;
            if (pop) begin
                exp_w = (q.size() > 0) ? q.pop_front() : 38'h3F_FFFF_FFFF;
                chk("stream_word", {m_axis_TDATA, m_axis_TSTRB, m_axis_TUSER, m_axis_TLAST}, exp_w);
                got++;
            end
            if (push) begin
                q.push_back({s_axis_TDATA, s_axis_TSTRB, s_axis_TUSER, s_axis_TLAST});
                sent++;
            end
            tick();
            chk("stream_fill", fill_level, q.size());
        end
        chk("stream_count", got, 1000);
        s_axis_TVALID = 1'b0; m_axis_TREADY = 1'b0;

        // Reset mid-operation at fill level 7
        for (int i = 0; i < 7; i++) begin
            s_axis_TVALID = 1'b1; s_axis_TDATA = 32'h50 + i; s_axis_TLAST = 1'b1;
            tick();
        end
        s_axis_TVALID = 1'b0;
        chk("pre_rst_fill", fill_level, 5'd7);
        #2 ARESETn = 1'b0;
        #1;
        chk("mid_rst_valid", m_axis_TVALID, 1'b0);
        chk("mid_rst_fill", fill_level, 5'd0);
        chk("mid_rst_afull", s_almost_full, 1'b0);
        tick();
        ARESETn = 1'b1;
        tick();
        s_axis_TVALID = 1'b1; s_axis_TDATA = 32'hA5; s_axis_TLAST = 1'b1;
        tick();
        s_axis_TVALID = 1'b0;
        chk("post_rst_valid", m_axis_TVALID, 1'b1);
        chk("post_rst_data", m_axis_TDATA, 32'hA5);
        chk("post_rst_fill", fill_level, 5'd1);
        m_axis_TREADY = 1'b1;
        tick();
        chk("post_rst_empty", m_axis_TVALID, 1'b0);
        m_axis_TREADY = 1'b0;

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Packet held until its last beat is stored
        for (int i = 0; i < 2; i++) begin
            s_axis_TVALID = 1'b1; s_axis_TDATA = 32'h10 + i; s_axis_TLAST = 1'b0;
            tick();
        end
        s_axis_TVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pkt_hold", m_axis_TVALID, 1'b0);
        end
        s_axis_TVALID = 1'b1; s_axis_TDATA = 32'h12; s_axis_TLAST = 1'b1;
        tick();
        s_axis_TVALID = 1'b0;
        m_axis_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pkt_valid", m_axis_TVALID, 1'b1);
            chk("pkt_data", m_axis_TDATA, 32'h10 + i);
            tick();
        end
        chk("pkt_done", m_axis_TVALID, 1'b0);

        // Packet longer than DEPTH drains through the full override
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 400 && out_idx < 20; cyc++) begin
            s_axis_TVALID = (in_idx < 20);
            s_axis_TDATA  = 32'h100 + in_idx;
            s_axis_TLAST  = (in_idx == 19);
            #1;
            push = s_axis_TVALID && s_axis_TREADY;
            pop  = m_axis_TVALID && m_axis_TREADY;
            if (pop) begin
                chk("long_data", m_axis_TDATA, 32'h100 + out_idx);
                out_idx++;
            end
            if (push) in_idx++;
            tick();
        end
        chk("long_count", out_idx, 20);
        s_axis_TVALID = 1'b0; m_axis_TREADY = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TDATA width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter USER_WIDTH, default 1, TUSER width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, storage entries (power of 2, >=2).
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2, occupancy at or above which s_almost_full asserts.
REQ-005 SHALL have one clock and an asynchronous active-low reset, ports as below.
REQ-006 ACLK  in  1  single clock; all logic on rising edge.
REQ-007 ARESETn  in  1  asynchronous active-low reset.
REQ-008 s_axis_TVALID / s_axis_TREADY  in / out  1 / 1  slave handshake.
REQ-009 s_axis_TDATA, s_axis_TSTRB, s_axis_TUSER, s_axis_TLAST  in  DATA_WIDTH, DATA_WIDTH/8, USER_WIDTH, 1  slave payload.
REQ-010 m_axis_TVALID / m_axis_TREADY  out / in  1 / 1  master handshake.
REQ-011 m_axis_TDATA, m_axis_TSTRB, m_axis_TUSER, m_axis_TLAST  out  same widths  master payload.
REQ-012 fill_level  out  $clog2(DEPTH)+1  stored entry count, 0..DEPTH.
REQ-013 s_almost_full  out  1  fill_level >= AFULL_THRESH.

Function
REQ-014 Push SHALL occur on an edge where s_axis_TVALID && s_axis_TREADY; pop where m_axis_TVALID && m_axis_TREADY.
REQ-015 s_axis_TREADY SHALL equal (fill_level != DEPTH), registered-state only, never dependent on m_axis_TREADY.
REQ-016 Output SHALL be first-word-fall-through: head entry's payload driven on m_axis_* while m_axis_TVALID=1.
REQ-017 Latency: a word pushed at edge N SHALL be presented on m_axis_* from edge N onward if FIFO was empty (one-cycle latency, no combinational bypass).
REQ-018 Payload (TDATA, TSTRB, TUSER, TLAST) SHALL be stored and delivered unchanged, in order, no loss or duplication.
REQ-019 Once m_axis_TVALID=1 it SHALL stay 1 with stable payload until a pop.
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; full = addresses equal and MSBs differ; empty = pointers equal.
REQ-021 Simultaneous push and pop SHALL leave fill_level unchanged; when full, no push occurs (TREADY=0) even if a pop occurs that edge.
REQ-022 Pop when empty and push when full SHALL be impossible by construction; fill_level SHALL never exceed DEPTH or underflow.
REQ-023 fill_level and s_almost_full SHALL be registered, reflecting state after the current edge.

Reset
REQ-024 On ARESETn=0, asynchronously: pointers=0, fill_level=0, s_axis_TREADY=1 after release, m_axis_TVALID=0, s_almost_full=0.
REQ-025 Reset mid-operation SHALL discard all stored entries and partial packets; memory contents need not be cleared.
REQ-026 m_axis_TDATA/TSTRB/TUSER/TLAST SHALL be don't-care while m_axis_TVALID=0.

Configuration
REQ-027 Macro AXIS_FIFO_PACKET_MODE_EN, when defined, SHALL enable packet mode; when undefined, REQ-016..017 apply unmodified.
REQ-028 Packet mode: pkt_cnt counter (width as fill_level) +1 on push with TLAST, -1 on pop with TLAST, unchanged if both.
REQ-029 Packet mode: m_axis_TVALID SHALL be (!empty && (pkt_cnt>0 || full)); full override prevents deadlock on packets longer than DEPTH.
REQ-030 Packet mode: once asserted via full override, m_axis_TVALID SHALL follow REQ-019 until the pop.

Structure
REQ-031 Package axis_pkg SHALL hold the payload struct typedef (tdata, tstrb, tuser, tlast) parametrised by width constants and ptr width function.
REQ-032 Storage SHALL be sub-module axis_fifo_ram: simple dual-port, one write, one asynchronous-read port, DEPTH x payload width.

Verification
REQ-033 Fill: DEPTH=16, push 16 words 0x0..0xF with m_axis_TREADY=0 -> s_axis_TREADY=0 after 16th, fill_level=16, s_almost_full=1 from fill_level 14.
REQ-034 Drain: from full, m_axis_TREADY=1 -> 0x0..0xF out in order on 16 consecutive edges, then m_axis_TVALID=0, fill_level=0.
REQ-035 Streaming: both sides random 50% valid/ready, 1000 words with random TSTRB/TUSER -> scoreboard exact match, fill_level never >16.
REQ-036 Reset: ARESETn=0 while fill_level=7 -> m_axis_TVALID=0 immediately, fill_level=0; subsequent word 0xA5 is first out.
REQ-037 Packet mode: push 3-beat packet, TLAST withheld 5 cycles -> m_axis_TVALID=0 until TLAST beat stored, then 3 beats out back-to-back.
REQ-038 Packet mode: 20-beat packet into DEPTH=16 -> m_axis_TVALID=1 once full, all 20 beats delivered, no deadlock.
